// File: rtl/fetch_stage_pkg.sv
// Shared types for the RV32I fetch stage: FSM states, opcode map, IF/ID payload.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  // Redirect targets are forced onto a word boundary rather than trapping.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read handshake between the fetch stage and I-memory.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_read;
  logic [XLEN-1:0] imem_address;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_resp;

  modport master (output imem_read, imem_address, input imem_rdata, imem_resp);
  modport slave  (input imem_read, imem_address, output imem_rdata, imem_resp);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// One-entry IF/ID payload register; load wins over flush, flush only kills valid.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '{valid: 1'b0, pc: '0, instr: RV32I_NOP};
    end else if (load) begin
      q <= d;
    end else if (flush) begin
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the I-memory handshake and feeds the IF/ID register
// through a one-entry skid buffer.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060
) (
  input  logic            clk,
  input  logic            rst,
  fetch_stage_if.master   imem,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  output rv32i_opcode_t   if_opcode_o,
  output logic [2:0]      if_funct3_o,
  output logic [6:0]      if_funct7_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] target;
  logic            out_free;

  if_id_t fetched, ifid_d, ifid_q, skid_q;
  logic   ifid_load, ifid_flush, skid_load, skid_flush;

  fetch_stage_if_id_reg u_ifid (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  fetch_stage_if_id_reg u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .flush (skid_flush),
    .d     (fetched),
    .q     (skid_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    skid_load  = 1'b0;
    skid_flush = 1'b0;
    target     = align_word(redirect_pc_i);
    out_free   = !ifid_q.valid || !stall_i;
    fetched    = '{valid: 1'b1, pc: pc_q, instr: imem.imem_rdata};
    ifid_d     = fetched;

    // Consumer drains IF/ID; a load below takes priority inside the register.
    if (ifid_q.valid && !stall_i) ifid_flush = 1'b1;

    unique case (state_q)
      REQ: begin
        if (imem.imem_resp) begin
          if (redirect_i) begin
            pc_d = target;
          end else if (out_free) begin
            ifid_load = 1'b1;
            pc_d      = pc_q + XLEN'(4);
          end else begin
            skid_load = 1'b1;
            pc_d      = pc_q + XLEN'(4);
            state_d   = WAIT;
          end
        end else if (redirect_i) begin
          tgt_d   = target;
          state_d = DRAIN;
        end
      end
      WAIT: begin
        if (redirect_i) begin
          skid_flush = 1'b1;
          pc_d       = target;
          state_d    = REQ;
        end else if (!stall_i) begin
          ifid_load  = 1'b1;
          ifid_d     = skid_q;
          skid_flush = 1'b1;
          state_d    = REQ;
        end
      end
      DRAIN: begin
        // The in-flight read must complete; its data is discarded.
        if (imem.imem_resp) begin
          pc_d    = redirect_i ? target : tgt_q;
          state_d = REQ;
        end else if (redirect_i) begin
          tgt_d = target;
        end
      end
      default: state_d = REQ;
    endcase

    if (redirect_i) begin
      ifid_load  = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // Read is gated by rst directly so an abandoned request drops in the reset cycle.
  assign imem.imem_read    = !rst && (state_q != WAIT);
  assign imem.imem_address = pc_q;

  assign if_valid_o  = ifid_q.valid;
  assign if_pc_o     = ifid_q.pc;
  assign if_instr_o  = ifid_q.instr;
  assign if_opcode_o = rv32i_opcode_t'(ifid_q.instr[6:0]);
  assign if_funct3_o = ifid_q.instr[14:12];
  assign if_funct7_o = ifid_q.instr[31:25];

endmodule
